// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if
//   Bundles the scan controller's data and pin signals.
//   master: counter chain side (drives enable, digits, decimal points,
//           observes the display pins).
//   slave : the scan controller itself.
//   Signals:
//     enableIn      scan enable, synchronous
//     digitsIn[15:0] four BCD/hex digits, [3:0] = digit 0
//     dpIn[3:0]     decimal point per digit
//     segOut[7:0]   segments a..g at [0]..[6], dp at [7]
//     digitSelOut[3:0] one-hot digit select
//     frameStartOut one-cycle pulse on snapshot capture
interface display_scan_controller_if;
  logic        enableIn;
  logic [15:0] digitsIn;
  logic [3:0]  dpIn;
  logic [7:0]  segOut;
  logic [3:0]  digitSelOut;
  logic        frameStartOut;

  modport master (
    output enableIn, digitsIn, dpIn,
    input  segOut, digitSelOut, frameStartOut
  );

  modport slave (
    input  enableIn, digitsIn, dpIn,
    output segOut, digitSelOut, frameStartOut
  );
endinterface

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexed scan of a 4-digit 7-segment display. Inputs are
//   double-registered, then snapshotted once per frame so a frame never
//   shows a value changing part way through. Each digit slot starts with
//   BLANK_CYCLES of all-off to suppress ghosting, then drives the digit.
//   Optional feature macro: LEADING_ZERO_BLANK_EN (darken leading zeros
//   on digits 3..1; digit 0 always shown, dp always follows its input).
//   Ports:
//     clk      system clock, rising edge
//     resetIn  asynchronous, active-low reset
//     scanBus  display_scan_controller_if.slave (enable, digits, dp in;
//              segOut, digitSelOut, frameStartOut out, all registered)
//
//   state | meaning
//   IDLE  | scan stopped, all outputs inactive
//   BLANK | digit index held, all outputs inactive
//   ON    | selected digit driven
module display_scan_controller #(
  parameter int CLK_HZ         = 27_000_000,
  parameter int DIGIT_HZ       = 1000,
  parameter int BLANK_CYCLES   = 270,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic                       clk,
  input logic                       resetIn,
  display_scan_controller_if.slave  scanBus
);

  localparam int TICKS = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICKS - 1);
  // Inactive levels double as XOR masks that apply polarity at the output.
  localparam logic [7:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= TICKS) begin : gBadBlank
    $error("BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < TICKS");
  end

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] slotCnt, slotCntNext;
  logic [1:0]       digitIdx, digitIdxNext;
  logic [19:0]      syncA, syncB;
  logic [15:0]      snapDigits;
  logic [3:0]       snapDp;
  logic             capture;
  logic             blankDigit;
  logic [3:0]       curDigit;
  logic [7:0]       segLit;
  logic [3:0]       selLit;

  function automatic logic [6:0] decode7(input logic [3:0] v);
    case (v)
      4'h0: decode7 = 7'h3F;
      4'h1: decode7 = 7'h06;
      4'h2: decode7 = 7'h5B;
      4'h3: decode7 = 7'h4F;
      4'h4: decode7 = 7'h66;
      4'h5: decode7 = 7'h6D;
      4'h6: decode7 = 7'h7D;
      4'h7: decode7 = 7'h07;
      4'h8: decode7 = 7'h7F;
      4'h9: decode7 = 7'h6F;
      4'hA: decode7 = 7'h77;
      4'hB: decode7 = 7'h7C;
      4'hC: decode7 = 7'h39;
      4'hD: decode7 = 7'h5E;
      4'hE: decode7 = 7'h79;
      default: decode7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    stateNext    = state;
    slotCntNext  = slotCnt;
    digitIdxNext = digitIdx;
    capture      = 1'b0;
    if (!scanBus.enableIn) begin
      stateNext    = IDLE;
      slotCntNext  = '0;
      digitIdxNext = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          stateNext    = BLANK;
          slotCntNext  = '0;
          digitIdxNext = 2'd0;
          capture      = 1'b1;
        end
        BLANK: begin
          slotCntNext = slotCnt + 1'b1;
          if (slotCnt == BLANK_LAST) stateNext = ON;
        end
        ON: begin
          if (slotCnt == SLOT_LAST) begin
            stateNext    = BLANK;
            slotCntNext  = '0;
            digitIdxNext = digitIdx + 2'd1;
            capture      = (digitIdx == 2'd3);
          end else begin
            slotCntNext = slotCnt + 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state. ON is only entered from BLANK/ON, never on a
  // capture edge, so the current snapshot is the one to show.
  always_comb begin
    curDigit   = snapDigits[{digitIdxNext, 2'b00} +: 4];
    blankDigit = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (digitIdxNext)
      2'd3:    blankDigit = (snapDigits[15:12] == 4'h0);
      2'd2:    blankDigit = (snapDigits[15:8] == 8'h00);
      2'd1:    blankDigit = (snapDigits[15:4] == 12'h000);
      default: blankDigit = 1'b0;
    endcase
`endif
    segLit = 8'h00;
    selLit = 4'h0;
    if (stateNext == ON) begin
      selLit[digitIdxNext] = 1'b1;
      segLit[7]            = snapDp[digitIdxNext];
      segLit[6:0]          = blankDigit ? 7'h00 : decode7(curDigit);
    end
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      state                 <= IDLE;
      slotCnt               <= '0;
      digitIdx              <= 2'd0;
      syncA                 <= '0;
      syncB                 <= '0;
      snapDigits            <= '0;
      snapDp                <= '0;
      scanBus.frameStartOut <= 1'b0;
      scanBus.segOut        <= SEG_IDLE;
      scanBus.digitSelOut   <= DIG_IDLE;
    end else begin
      state                 <= stateNext;
      slotCnt               <= slotCntNext;
      digitIdx              <= digitIdxNext;
      syncA                 <= {scanBus.dpIn, scanBus.digitsIn};
      syncB                 <= syncA;
      if (capture) {snapDp, snapDigits} <= syncB;
      scanBus.frameStartOut <= capture;
      scanBus.segOut        <= segLit ^ SEG_IDLE;
      scanBus.digitSelOut   <= selLit ^ DIG_IDLE;
    end
  end

endmodule
